// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  localparam int unsigned MAX_LATENCY = 15;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store merge, zero-extended load extract, alignment fault.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] data_in,
  input  logic [31:0] read_word,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        align_fault
);

  logic [4:0] shift;

  assign shift = {addr_lo, 3'b000};

  always_comb begin
    store_word  = old_word;
    load_data   = '0;
    align_fault = 1'b0;
    case (size)
      MEM_WORD: begin
        store_word  = data_in;
        load_data   = read_word;
        align_fault = (addr_lo != 2'b00);
      end
      MEM_HALF: begin
        if (addr_lo[1]) begin
          store_word[31:16] = data_in[15:0];
          load_data[15:0]   = read_word[31:16];
        end else begin
          store_word[15:0] = data_in[15:0];
          load_data[15:0]  = read_word[15:0];
        end
        align_fault = addr_lo[0];
      end
      MEM_BYTE: begin
        store_word[shift +: 8] = data_in[7:0];
        load_data[7:0]         = read_word[shift +: 8];
      end
      default: align_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder with lane-masked stores, zero-extended loads and access faults.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] Datain,
  output logic        Busy,
  output logic        Ready,
  output logic        Err,
  output logic [31:0] Dataout
);

  localparam int unsigned IW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CntInit   = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  resp_state_t state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=1 the access completes on the accepting edge, before the latches hold it.
  logic        sel_in;
  logic        a_wr;
  logic [1:0]  a_size;
  logic [31:0] a_addr;
  logic [31:0] a_data;
  logic [IW-1:0] idx;
  logic [31:0] old_word;
  logic [31:0] store_word;
  logic [31:0] load_data;
  logic        align_fault;
  logic        range_fault;
  logic        fault;
  logic        finish;
  logic        do_write;

  assign sel_in      = (state_q == IDLE);
  assign a_wr        = sel_in ? Wr      : wr_q;
  assign a_size      = sel_in ? Size    : size_q;
  assign a_addr      = sel_in ? Address : addr_q;
  assign a_data      = sel_in ? Datain  : data_q;
  assign idx         = a_addr[IW+1:2];
  assign old_word    = mem[idx];
  assign range_fault = ({1'b0, a_addr} >= ByteLimit);
  assign fault       = align_fault | range_fault;
  assign finish      = ((state_q == IDLE) && Req && (LATENCY == 1)) ||
                       ((state_q == WAIT) && (cnt_q == 4'd0));
  assign do_write    = finish && a_wr && !fault && Reset;

  mem_lane_align u_align (
    .size        (a_size),
    .addr_lo     (a_addr[1:0]),
    .old_word    (old_word),
    .data_in     (a_data),
    .read_word   (old_word),
    .store_word  (store_word),
    .load_data   (load_data),
    .align_fault (align_fault)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      Busy    <= 1'b0;
      Ready   <= 1'b0;
      Err     <= 1'b0;
      Dataout <= '0;
    end else begin
      Ready <= 1'b0;
      Err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Req) begin
            wr_q   <= Wr;
            size_q <= Size;
            addr_q <= Address;
            data_q <= Datain;
            Busy   <= 1'b1;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= CntInit;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          Busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (finish) begin
        Ready <= 1'b1;
        Err   <= fault;
        if (!a_wr && !fault) begin
          Dataout <= load_data;
        end
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (do_write) begin
      mem[idx] <= store_word;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a behavioural memory model.
module tb_mem_responder;

  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_a, wr_a;
  logic [1:0]  size_a;
  logic [31:0] addr_a, din_a, dout_a;
  logic        busy_a, ready_a, err_a;

  logic        req_b, wr_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, din_b, dout_b;
  logic        busy_b, ready_b, err_b;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_A)) u_dut_a (
    .Clk     (clk),
    .Reset   (rst_n),
    .Req     (req_a),
    .Wr      (wr_a),
    .Size    (size_a),
    .Address (addr_a),
    .Datain  (din_a),
    .Busy    (busy_a),
    .Ready   (ready_a),
    .Err     (err_a),
    .Dataout (dout_a)
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_b (
    .Clk     (clk),
    .Reset   (rst_n),
    .Req     (req_b),
    .Wr      (wr_b),
    .Size    (size_b),
    .Address (addr_b),
    .Datain  (din_b),
    .Busy    (busy_b),
    .Ready   (ready_b),
    .Err     (err_b),
    .Dataout (dout_b)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [31:0] exp_dout;
  logic [31:0] bmem [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (ad % 2) != 0) return 1'b1;
    if (sz == 2'd0 && (ad % 4) != 0) return 1'b1;
    if (ad >= 32'd1024) return 1'b1;
    return 1'b0;
  endfunction

  // Called #1 after a rising edge with DUT A idle; returns in the same phase.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] dt);
    logic        f;
    int          cycles;
    int          sh;
    logic [31:0] w, mask;
    f  = model_fault(sz, ad);
    sh = int'(ad % 4) * 8;
    req_a = 1'b1; wr_a = wr; size_a = sz; addr_a = ad; din_a = dt;
    @(posedge clk); #1;
    req_a = 1'b0;
    cycles = 1;
    while (!ready_a && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("latency", 32'(cycles), 32'(LAT_A));
    check("busy_in_resp", 32'(busy_a), 32'd1);
    check("err", 32'(err_a), 32'(f));
    if (!f) begin
      w = model_mem[ad / 4];
      if (wr) begin
        mask = (sz == 2'd0) ? 32'hFFFF_FFFF : (sz == 2'd1) ? (32'hFFFF << sh) : (32'hFF << sh);
        model_mem[ad / 4] = (w & ~mask) | ((dt << sh) & mask);
      end else begin
        exp_dout = (sz == 2'd0) ? w : (sz == 2'd1) ? ((w >> sh) & 32'hFFFF) : ((w >> sh) & 32'hFF);
      end
    end
    check("dataout", dout_a, exp_dout);
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(ready_a), 32'd0);
    check("err_without_ready", 32'(err_a), 32'd0);
    check("busy_idle", 32'(busy_a), 32'd0);
  endtask

  initial begin
    logic [31:0] ad;
    logic [1:0]  sz;
    rst_n = 1'b0;
    req_a = 1'b0; wr_a = 1'b0; size_a = '0; addr_a = '0; din_a = '0;
    req_b = 1'b0; wr_b = 1'b0; size_b = '0; addr_b = '0; din_b = '0;
    exp_dout = '0;
    #12;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_dout", dout_a, 32'd0);
    check("rst_b_ready", 32'(ready_b), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) do_req(1'b1, 2'd0, 32'(i * 4), $urandom);

    do_req(1'b1, 2'd0, 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd0, 32'h10, 32'h0);
    check("plan_word", dout_a, 32'hDEAD_BEEF);
    do_req(1'b1, 2'd2, 32'h11, 32'h0000_00AA);
    do_req(1'b0, 2'd0, 32'h10, 32'h0);
    check("plan_byte_merge", dout_a, 32'hDEAD_AAEF);
    do_req(1'b0, 2'd2, 32'h13, 32'h0);
    check("plan_byte_load", dout_a, 32'h0000_00DE);
    do_req(1'b1, 2'd1, 32'h12, 32'h0000_1234);
    do_req(1'b0, 2'd1, 32'h12, 32'h0);
    check("plan_half_load", dout_a, 32'h0000_1234);
    do_req(1'b0, 2'd1, 32'h11, 32'h0);
    check("plan_fault_dout_hold", dout_a, 32'h0000_1234);
    do_req(1'b1, 2'd1, 32'h11, 32'h0000_5555);
    do_req(1'b0, 2'd0, 32'h10, 32'h0);
    check("plan_after_faults", dout_a, 32'h1234_AAEF);
    do_req(1'b0, 2'd0, 32'h400, 32'h0);
    do_req(1'b1, 2'd0, 32'h400, 32'h1111_1111);
    do_req(1'b1, 2'd3, 32'h0, 32'h2222_2222);
    do_req(1'b0, 2'd0, 32'h0, 32'h0);

    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ad = 32'h400 + 32'($urandom_range(0, 4095));
      else if ($urandom_range(0, 19) == 0) ad = $urandom;
      else ad = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd0) ad = ad & ~32'h3;
        if (sz == 2'd1) ad = ad & ~32'h1;
      end
      do_req(1'($urandom_range(0, 1)), sz, ad, $urandom);
    end

    // Reset in the middle of a store must abort it.
    req_a = 1'b1; wr_a = 1'b1; size_a = 2'd0; addr_a = 32'h20; din_a = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ready", 32'(ready_a), 32'd0);
    check("abort_err", 32'(err_a), 32'd0);
    check("abort_dout", dout_a, 32'd0);
    exp_dout = '0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 2'd0, 32'h20, 32'h0);

    // LATENCY=1 with Req held: four stores then four loads, accepted every other cycle.
    for (int i = 0; i < 4; i++) bmem[i] = $urandom;
    req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_b = (i < 4); size_b = 2'd0; addr_b = 32'((i % 4) * 4); din_b = bmem[i % 4];
      @(posedge clk); #1;
      check("b_ready", 32'(ready_b), 32'd1);
      check("b_busy_resp", 32'(busy_b), 32'd1);
      check("b_err", 32'(err_b), 32'd0);
      if (i >= 4) check("b_dout", dout_b, bmem[i % 4]);
      @(posedge clk); #1;
      check("b_ready_gap", 32'(ready_b), 32'd0);
      check("b_busy_gap", 32'(busy_b), 32'd0);
    end
    req_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("b_no_extra", 32'(ready_b), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's data/instruction memory port.
- Accepts one request at a time (read or write; word, halfword or byte) and services it after a fixed, parameterised latency.
- Signals completion with a one-cycle Ready pulse and returns zero-extended load data.
- Replaces the zero-wait memory model so the control unit can be exercised against real wait states, lane-masked stores and access faults.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; valid byte addresses 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, cycles from request acceptance to Ready; legal range 1..15.

Ports:
- Clk  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  1  request valid; sampled only in IDLE.
- Wr  input  1  1 = store, 0 = load.
- Size  input  2  00 word, 01 halfword, 10 byte, 11 reserved.
- Address  input  32  byte address.
- Datain  input  32  store data; the lane value is taken from the LSBs (bits 7:0 or 15:0).
- Busy  output  1  high from the cycle after acceptance through the Ready cycle.
- Ready  output  1  one-cycle completion pulse.
- Err  output  1  valid only with Ready; 1 = faulted access.
- Dataout  output  32  load result, zero-extended, right-justified.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state IDLE; Busy=0, Ready=0, Err=0, Dataout=0.
  - Storage contents are not cleared.
  - Reset mid-operation aborts the access; no array write occurs.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On Req=1, latch Wr, Size, Address and Datain.
  - If LATENCY=1, go to RESP; otherwise load the counter with LATENCY-2 and go to WAIT.
- WAIT: decrement the counter; go to RESP when it reaches 0.
- RESP:
  - Ready=1 for exactly this cycle; then return to IDLE.
  - Ready is high exactly LATENCY cycles after the edge that accepted Req.
- Req while Busy=1 is ignored and not queued.
- Back-to-back requests:
  - Req held high in the RESP cycle is not accepted.
  - Acceptance happens on the following IDLE cycle.
  - Minimum request spacing is therefore LATENCY+1 cycles.
- Fault checks, evaluated on the latched request:
  - Size=11 is a fault.
  - Size=01 with Address[0]=1 is a fault.
  - Size=00 with Address[1:0]≠00 is a fault.
  - Address >= 4*DEPTH_WORDS is a fault.
  - On fault: Err=1 with Ready, no array write, Dataout unchanged.
- Byte lanes are little-endian: byte k of a word occupies bits 8k+7:8k, with k = Address[1:0].
- Store:
  - Only the addressed lane(s) of word Address[..:2] are written.
  - Other bytes are preserved.
  - The array is updated on the same edge at which Ready rises. A load accepted afterwards sees the new data.
  - Dataout is unchanged by stores.
- Load:
  - Dataout is registered and updated on the edge at which Ready rises.
  - Word: the full word.
  - Halfword: {16'b0, selected half}.
  - Byte: {24'b0, selected byte}.
  - Dataout holds until the next successful load.
- Err=0 whenever Ready=0.
- Width rules:
  - Counter width is 4 bits.
  - The word index is Address[$clog2(DEPTH_WORDS)+1:2]; the upper address bits are used only for the range check.

Decomposition:
- Shared package mem_pkg holds:
  - typedef enum mem_size_t {MEM_WORD=2'b00, MEM_HALF=2'b01, MEM_BYTE=2'b10}.
  - typedef enum resp_state_t {IDLE, WAIT, RESP}.
  - constant MAX_LATENCY=15.
- One natural sub-module, mem_lane_align (combinational), provides:
  - given Size, Address[1:0], the old word and Datain: the merged store word;
  - given Size, Address[1:0] and the read word: the zero-extended load value;
  - the alignment-fault flag.
- The FSM, counter, latches and storage array stay in mem_responder.

Test Plan:
- Reset then word store 0xDEADBEEF at 0x10, then word load at 0x10 (LATENCY=2) -> each Ready exactly 2 cycles after acceptance, Err=0, Dataout=0xDEADBEEF.
- Byte store 0x000000AA at 0x11 over 0xDEADBEEF, then word load at 0x10 -> Dataout=0xDEADAAEF; byte load at 0x13 -> Dataout=0x000000DE.
- Halfword store 0x1234 at 0x12, then halfword load at 0x12 -> Dataout=0x00001234; halfword at 0x11 -> Ready with Err=1, memory and Dataout unchanged.
- Load at address 0x400 (DEPTH_WORDS=256) -> Err=1; Size=11 at 0x0 -> Err=1; no array write in either case.
- Req held continuously, LATENCY=1 -> acceptance every 2 cycles; Busy=1 exactly in each RESP cycle; no request is lost or duplicated.
- Reset asserted during WAIT of a store of 0xFFFFFFFF to 0x20 -> outputs return to 0 immediately (asynchronously); a later load at 0x20 returns the prior contents.
